// File: rtl/pio_cpl_tracker.sv
// rtl/pio_cpl_tracker.sv - outstanding non-posted completion tracker with timeout and turn-off handshake
module pio_cpl_tracker #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1),
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int TCQ             = 1
) (
    input  logic                 s_axis_aclk,
    input  logic                 user_reset,
    input  logic                 user_lnk_up,
    input  logic                 req_compl,
    input  logic                 compl_done,
    input  logic                 cfg_to_turnoff,
    output logic                 cfg_turnoff_ok,
    output logic                 req_stall,
    output logic [CNT_WIDTH-1:0] outstanding,
    output logic                 timeout_abort,
    output logic                 err_overflow,
    output logic                 err_underflow
);

    localparam int TMR_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] MAX_CNT  = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [TMR_WIDTH-1:0] TMR_LAST =
        TMR_WIDTH'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 255 || TIMEOUT_CYCLES < 0 || TCQ < 0) begin : g_bad_params
        $error("pio_cpl_tracker: illegal parameter value");
    end

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_OK     = 2'd2
    } state_t;

    logic                 rst_q;
    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [TMR_WIDTH-1:0] timer_q, timer_d;
    logic                 abort_q, abort_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;

    always_ff @(posedge s_axis_aclk) begin
        rst_q <= user_reset | ~user_lnk_up;
        if (rst_q) begin
            state_q <= ST_ACTIVE;
            count_q <= '0;
            timer_q <= '0;
            abort_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            timer_q <= timer_d;
            abort_q <= abort_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // A simultaneous request and completion cancel out, even at the limits.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        case ({req_compl, compl_done})
            2'b10: begin
                if (count_q == MAX_CNT) ovf_d = 1'b1;
                else                    count_d = count_q + CNT_WIDTH'(1);
            end
            2'b01: begin
                if (count_q == '0) unf_d = 1'b1;
                else               count_d = count_q - CNT_WIDTH'(1);
            end
            default: ;
        endcase
    end

    // A completion counts as progress, so it suppresses an abort due the same cycle.
    always_comb begin
        timer_d = '0;
        abort_d = 1'b0;
        if (TIMEOUT_CYCLES != 0 && count_q != '0 && !compl_done) begin
            if (timer_q == TMR_LAST) abort_d = 1'b1;
            else                     timer_d = timer_q + TMR_WIDTH'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACTIVE: begin
                if (cfg_to_turnoff) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!cfg_to_turnoff)                     state_d = ST_ACTIVE;
                else if (count_q == '0 && !req_compl)    state_d = ST_OK;
            end
            ST_OK: begin
                if (!cfg_to_turnoff) state_d = ST_ACTIVE;
                else if (req_compl)  state_d = ST_DRAIN;
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    assign cfg_turnoff_ok = (state_q == ST_OK);
    assign req_stall      = (count_q == MAX_CNT) | (state_q != ST_ACTIVE);
    assign outstanding    = count_q;
    assign timeout_abort  = abort_q;
    assign err_overflow   = ovf_q;
    assign err_underflow  = unf_q;

endmodule

// File: tb/tb_pio_cpl_tracker.sv
// tb/tb_pio_cpl_tracker.sv - self-checking bench for pio_cpl_tracker against a behavioural model
module tb_pio_cpl_tracker;

    localparam int MAX = 4;
    localparam int TMO = 16;
    localparam int CW  = $clog2(MAX + 1);

    logic          clk = 1'b0;
    logic          user_reset, user_lnk_up, req_compl, compl_done, cfg_to_turnoff;
    logic          cfg_turnoff_ok, req_stall, timeout_abort, err_overflow, err_underflow;
    logic [CW-1:0] outstanding;

    int  total = 0;
    int  bad   = 0;
    bit  chk_en = 1'b0;

    // behavioural model state
    bit m_rst = 1'b0;
    int m_cnt = 0;
    int m_idle = 0;
    bit m_abort = 1'b0, m_ovf = 1'b0, m_unf = 1'b0, m_drain = 1'b0, m_ok = 1'b0;

    always #5 clk = ~clk;

    pio_cpl_tracker #(
        .MAX_OUTSTANDING(MAX),
        .TIMEOUT_CYCLES (TMO),
        .TCQ            (1)
    ) dut (
        .s_axis_aclk   (clk),
        .user_reset    (user_reset),
        .user_lnk_up   (user_lnk_up),
        .req_compl     (req_compl),
        .compl_done    (compl_done),
        .cfg_to_turnoff(cfg_to_turnoff),
        .cfg_turnoff_ok(cfg_turnoff_ok),
        .req_stall     (req_stall),
        .outstanding   (outstanding),
        .timeout_abort (timeout_abort),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        bit req, done;
        int old_cnt;
        req = req_compl;
        done = compl_done;
        old_cnt = m_cnt;
        if (m_rst) begin
            m_cnt = 0; m_idle = 0; m_abort = 0; m_ovf = 0; m_unf = 0; m_drain = 0; m_ok = 0;
        end else begin
            m_abort = 0;
            if (TMO == 0 || old_cnt == 0 || done) m_idle = 0;
            else if (m_idle == TMO - 1) begin m_idle = 0; m_abort = 1; end
            else m_idle++;
            if (req && !done) begin
                if (old_cnt == MAX) m_ovf = 1; else m_cnt++;
            end else if (done && !req) begin
                if (old_cnt == 0) m_unf = 1; else m_cnt--;
            end
            if (!cfg_to_turnoff) begin
                m_drain = 0; m_ok = 0;
            end else if (m_ok) begin
                if (req) begin m_ok = 0; m_drain = 1; end
            end else if (m_drain) begin
                if (old_cnt == 0 && !req) begin m_drain = 0; m_ok = 1; end
            end else begin
                m_drain = 1;
            end
        end
        m_rst = user_reset | ~user_lnk_up;
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("model_outstanding", 32'(outstanding), 32'(m_cnt));
            check("model_stall", 32'(req_stall), 32'((m_cnt == MAX) || m_drain || m_ok));
            check("model_ok", 32'(cfg_turnoff_ok), 32'(m_ok));
            check("model_abort", 32'(timeout_abort), 32'(m_abort));
            check("model_ovf", 32'(err_overflow), 32'(m_ovf));
            check("model_unf", 32'(err_underflow), 32'(m_unf));
        end
    end

    task automatic pulse(input bit r, input bit d);
        req_compl  = r;
        compl_done = d;
        @(negedge clk);
        req_compl  = 1'b0;
        compl_done = 1'b0;
    endtask

    initial begin
        bit abort_seen;
        int pr_req, pr_done;
        user_reset = 1'b1; user_lnk_up = 1'b1;
        req_compl = 1'b0; compl_done = 1'b0; cfg_to_turnoff = 1'b0;

        // reset
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_outstanding", 32'(outstanding), 0);
        check("rst_stall", 32'(req_stall), 0);
        check("rst_ok", 32'(cfg_turnoff_ok), 0);
        check("rst_abort", 32'(timeout_abort), 0);
        check("rst_ovf", 32'(err_overflow), 0);
        check("rst_unf", 32'(err_underflow), 0);
        user_reset = 1'b0;
        repeat (2) @(negedge clk);

        // fill / overflow / drain
        for (int i = 1; i <= 4; i++) begin
            pulse(1, 0);
            check("fill_outstanding", 32'(outstanding), 32'(i));
            check("fill_stall", 32'(req_stall), 32'(i == 4));
        end
        pulse(1, 0);
        check("ovf_flag", 32'(err_overflow), 1);
        check("ovf_hold", 32'(outstanding), 4);
        for (int i = 3; i >= 0; i--) begin
            pulse(0, 1);
            check("drain_outstanding", 32'(outstanding), 32'(i));
        end
        check("drain_stall", 32'(req_stall), 0);

        // simultaneous and underflow
        pulse(1, 0); pulse(1, 0);
        pulse(1, 1);
        check("simul_hold", 32'(outstanding), 2);
        pulse(0, 1); pulse(0, 1);
        check("unf_clear_before", 32'(err_underflow), 0);
        pulse(0, 1);
        check("unf_flag", 32'(err_underflow), 1);
        check("unf_hold", 32'(outstanding), 0);

        // link drop behaves as reset one cycle late
        user_lnk_up = 1'b0;
        @(negedge clk);
        user_lnk_up = 1'b1;
        check("lnk_delay_ovf", 32'(err_overflow), 1);
        @(negedge clk);
        check("lnk_ovf_clr", 32'(err_overflow), 0);
        check("lnk_unf_clr", 32'(err_underflow), 0);
        @(negedge clk);

        // timeout
        pulse(1, 0);
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (i == 15) check("tmo_early", 32'(timeout_abort), 0);
            if (i == 16) check("tmo_first", 32'(timeout_abort), 1);
            if (i == 17) check("tmo_single", 32'(timeout_abort), 0);
            if (i == 32) check("tmo_second", 32'(timeout_abort), 1);
        end
        check("tmo_count_kept", 32'(outstanding), 1);
        pulse(0, 1);
        abort_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            abort_seen |= timeout_abort;
        end
        check("tmo_quiet", 32'(abort_seen), 0);

        // turn-off with count 2
        pulse(1, 0); pulse(1, 0);
        cfg_to_turnoff = 1'b1;
        @(negedge clk);
        check("to_stall", 32'(req_stall), 1);
        check("to_ok_low", 32'(cfg_turnoff_ok), 0);
        pulse(0, 1); pulse(0, 1);
        check("to_cnt0", 32'(outstanding), 0);
        check("to_ok_wait", 32'(cfg_turnoff_ok), 0);
        @(negedge clk);
        check("to_ok_high", 32'(cfg_turnoff_ok), 1);
        cfg_to_turnoff = 1'b0;
        @(negedge clk);
        check("to_release_ok", 32'(cfg_turnoff_ok), 0);
        check("to_release_stall", 32'(req_stall), 0);

        // abort in DRAIN, reset in OK
        pulse(1, 0);
        cfg_to_turnoff = 1'b1;
        @(negedge clk);
        check("ab_drain_stall", 32'(req_stall), 1);
        cfg_to_turnoff = 1'b0;
        @(negedge clk);
        check("ab_active_stall", 32'(req_stall), 0);
        pulse(0, 1);
        cfg_to_turnoff = 1'b1;
        repeat (2) @(negedge clk);
        check("ab_min_latency_ok", 32'(cfg_turnoff_ok), 1);
        user_reset = 1'b1;
        @(negedge clk);
        check("ab_rst_delay_ok", 32'(cfg_turnoff_ok), 1);
        @(negedge clk);
        check("ab_rst_ok", 32'(cfg_turnoff_ok), 0);
        check("ab_rst_cnt", 32'(outstanding), 0);
        user_reset = 1'b0;
        cfg_to_turnoff = 1'b0;
        repeat (2) @(negedge clk);

        // randomized traffic
        pr_req = 40; pr_done = 35;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                pr_req  = $urandom_range(10, 70);
                pr_done = $urandom_range(0, 60);
            end
            req_compl  = ($urandom_range(0, 99) < pr_req);
            compl_done = ($urandom_range(0, 99) < pr_done);
            if ($urandom_range(0, 39) == 0) cfg_to_turnoff = ~cfg_to_turnoff;
            user_reset  = ($urandom_range(0, 399) == 0);
            user_lnk_up = ($urandom_range(0, 499) != 0);
            @(negedge clk);
        end
        req_compl = 1'b0; compl_done = 1'b0; user_reset = 1'b0; user_lnk_up = 1'b1;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
